uart_alu_interface: RTL
=======================

// Module: uart_alu_interface
// PURPOSE
//  Control stage between UART receiver/transmitter and the combinational ALU.
//  Collects three received bytes in order (operand A, operand B, opcode) and drives them to the ALU.
//  Captures the ALU result and hands it to the UART transmitter as one byte, then waits for tx done.
//  Sits inside the system top, directly downstream of the UART rx path and upstream of the UART tx path.
// PARAMETERS
//  SIZEDATA  8  operand/result width; equals the UART data byte width
//  SIZEOP    6  opcode width; taken from i_rx_data[SIZEOP-1:0]
// PORTS
//  i_clock        in   1         system clock; all logic on rising edge
//  i_reset        in   1         synchronous, active-high reset
//  i_rx_done      in   1         1-cycle pulse: i_rx_data holds a new byte
//  i_rx_data      in   SIZEDATA  received byte
//  i_rx_err       in   1         parity error on current byte; sampled only with i_rx_done
//  i_alu_result   in   SIZEDATA  combinational ALU output
//  i_tx_done      in   1         1-cycle pulse: transmitter finished the byte
//  o_alu_a        out  SIZEDATA  registered operand A
//  o_alu_b        out  SIZEDATA  registered operand B
//  o_alu_op       out  SIZEOP    registered opcode
//  o_tx_signal    out  1         1-cycle pulse: start transmission of o_tx_data
//  o_tx_data      out  SIZEDATA  registered result byte, stable from o_tx_signal until i_tx_done
//  o_busy         out  1         high in EXEC, SEND, WAIT_TX
//  o_err          out  1         1-cycle pulse: sequence aborted (parity error or invalid opcode)
// BEHAVIOUR
//  Reset: state=GET_A; o_alu_a/b/op=0, o_tx_data=0, o_tx_signal=0, o_busy=0, o_err=0.
//  FSM (one-hot or binary, registered), transitions on rising edge:
//   GET_A : rx_done & !rx_err -> latch A, go GET_B
//   GET_B : rx_done & !rx_err -> latch B, go GET_OP
//   GET_OP: rx_done & !rx_err & valid op -> latch op, go EXEC
//           rx_done & invalid op -> o_err pulse, go GET_A; A/B/op registers unchanged
//   EXEC  : 1 cycle for ALU to settle on new op -> go SEND
//   SEND  : o_tx_data <= i_alu_result; o_tx_signal=1 for this cycle only -> go WAIT_TX
//   WAIT_TX: i_tx_done -> go GET_A
//  rx_done & rx_err in any GET_* state: byte discarded, o_err pulse next cycle, go GET_A.
//  Latency: opcode rx_done at edge N -> o_alu_op valid after N, EXEC cycle N+1,
//   o_tx_signal high cycle N+2 (exactly 3 cycles from op byte to tx start).
//  rx_done in EXEC/SEND/WAIT_TX: byte dropped, no error, state unaffected.
//  i_tx_done outside WAIT_TX: ignored.
//  Upper (SIZEDATA-SIZEOP) bits of opcode byte ignored.
//  Valid opcodes: ADD 6'b100000, SUB 100010, AND 100100, OR 100101, XOR 100110,
//   NOR 100111, SRA 000011, SRL 000010; anything else invalid.
//  o_alu_a/b/op hold last latched values after result sent (ALU output remains observable).
//  Reset mid-operation (any state) returns to GET_A in one cycle; pending tx pulse suppressed.
// STRUCTURE
//  Shared package: opcode localparams (OP_ADD..OP_SRL), state encodings, SIZEDATA/SIZEOP defaults,
//   and function is_valid_op(op) reused by the ALU and bench.
//  Single module, no sub-modules; ALU stays external and is wired by the system top.
// TESTING
//  Reset then rx A=8'h05, B=8'h03, OP=8'h20; ALU stub adds -> o_tx_signal 3 cycles after op, o_tx_data=8'h08.
//  After SEND, pulse i_tx_done after 100 cycles -> o_busy stays 1 until then, returns to GET_A; next trio accepted.
//  A=8'hF0, B=8'h0F, OP=8'h3F (invalid) -> o_err pulse, no o_tx_signal, next A accepted as operand A.
//  A ok, B with i_rx_err=1 -> o_err pulse, state GET_A; following A,B,OP=8'h22 -> SUB result sent.
//  Extra rx_done pulses during WAIT_TX -> ignored, o_alu_a/b unchanged, no o_err.
//  Assert i_reset in WAIT_TX and in GET_OP -> all outputs 0 next cycle, no stale o_tx_signal.

Source files
------------

// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the UART <-> ALU control stage:
// default widths, ALU opcode encodings, FSM state encoding and opcode validity check.
package uart_alu_interface_pkg;

    localparam int unsigned DEF_SIZEDATA = 8;
    localparam int unsigned DEF_SIZEOP   = 6;

    localparam logic [DEF_SIZEOP-1:0] OP_ADD = 6'b100000;
    localparam logic [DEF_SIZEOP-1:0] OP_SUB = 6'b100010;
    localparam logic [DEF_SIZEOP-1:0] OP_AND = 6'b100100;
    localparam logic [DEF_SIZEOP-1:0] OP_OR  = 6'b100101;
    localparam logic [DEF_SIZEOP-1:0] OP_XOR = 6'b100110;
    localparam logic [DEF_SIZEOP-1:0] OP_NOR = 6'b100111;
    localparam logic [DEF_SIZEOP-1:0] OP_SRA = 6'b000011;
    localparam logic [DEF_SIZEOP-1:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ST_GET_A   = 3'd0,
        ST_GET_B   = 3'd1,
        ST_GET_OP  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    // True for the eight opcodes the ALU implements.
    function automatic logic is_valid_op(input logic [DEF_SIZEOP-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_alu_interface.sv
// Control stage between the UART rx/tx paths and the external combinational ALU.
// Collects operand A, operand B and opcode bytes, holds them on the ALU inputs,
// captures the ALU result and hands it to the transmitter, then waits for tx done.
// Ports:
//   i_clock, i_reset           clock, synchronous active-high reset
//   i_rx_done/i_rx_data/i_rx_err  received byte strobe, byte, parity error
//   i_alu_result               combinational ALU output
//   i_tx_done                  transmitter finished the byte
//   o_alu_a/o_alu_b/o_alu_op   registered ALU operands and opcode
//   o_tx_signal/o_tx_data      one-cycle tx start strobe and registered result byte
//   o_busy                     high while a result is computed or sent
//   o_err                      one-cycle pulse when a sequence is aborted
module uart_alu_interface
    import uart_alu_interface_pkg::*;
#(
    parameter int unsigned SIZEDATA = DEF_SIZEDATA,
    parameter int unsigned SIZEOP   = DEF_SIZEOP
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_rx_done,
    input  logic [SIZEDATA-1:0] i_rx_data,
    input  logic                i_rx_err,
    input  logic [SIZEDATA-1:0] i_alu_result,
    input  logic                i_tx_done,
    output logic [SIZEDATA-1:0] o_alu_a,
    output logic [SIZEDATA-1:0] o_alu_b,
    output logic [SIZEOP-1:0]   o_alu_op,
    output logic                o_tx_signal,
    output logic [SIZEDATA-1:0] o_tx_data,
    output logic                o_busy,
    output logic                o_err
);

    state_t state_q;
    state_t state_d;

    logic load_a;
    logic load_b;
    logic load_op;
    logic load_tx;
    logic err_d;
    logic busy_d;
    logic op_ok;

    assign op_ok = is_valid_op(DEF_SIZEOP'(i_rx_data[SIZEOP-1:0]));

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_GET_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and register-load decode
    always_comb begin
        state_d = state_q;
        load_a  = 1'b0;
        load_b  = 1'b0;
        load_op = 1'b0;
        load_tx = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_GET_A: begin
                if (i_rx_done) begin
                    if (i_rx_err) begin
                        err_d = 1'b1;
                    end else begin
                        load_a  = 1'b1;
                        state_d = ST_GET_B;
                    end
                end
            end
            ST_GET_B: begin
                if (i_rx_done) begin
                    if (i_rx_err) begin
                        err_d   = 1'b1;
                        state_d = ST_GET_A;
                    end else begin
                        load_b  = 1'b1;
                        state_d = ST_GET_OP;
                    end
                end
            end
            ST_GET_OP: begin
                if (i_rx_done) begin
                    if (i_rx_err || !op_ok) begin
                        err_d   = 1'b1;
                        state_d = ST_GET_A;
                    end else begin
                        load_op = 1'b1;
                        state_d = ST_EXEC;
                    end
                end
            end
            // ALU has settled on the new operands by the end of EXEC; capture
            // the result so it and the tx strobe are both registered during SEND.
            ST_EXEC: begin
                load_tx = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = ST_GET_A;
                end
            end
            default: begin
                state_d = ST_GET_A;
            end
        endcase
        busy_d = (state_d == ST_EXEC) || (state_d == ST_SEND) || (state_d == ST_WAIT_TX);
    end

    // Output and datapath registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_alu_a     <= '0;
            o_alu_b     <= '0;
            o_alu_op    <= '0;
            o_tx_data   <= '0;
            o_tx_signal <= 1'b0;
            o_busy      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            if (load_a) begin
                o_alu_a <= i_rx_data;
            end
            if (load_b) begin
                o_alu_b <= i_rx_data;
            end
            if (load_op) begin
                o_alu_op <= i_rx_data[SIZEOP-1:0];
            end
            if (load_tx) begin
                o_tx_data <= i_alu_result;
            end
            o_tx_signal <= load_tx;
            o_busy      <= busy_d;
            o_err       <= err_d;
        end
    end

endmodule
